// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited bus requester with an in-order response
// FIFO, branch flush and discard of stale in-flight responses.
module instr_fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [INST_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  err_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [INST_WIDTH-1:0] instr_rdata_i,
  input  logic                  instr_err_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQ, REDIR} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic [ADDR_WIDTH-1:0] redir_addr_q;
  logic [ADDR_WIDTH-1:0] resp_pc_q;
  logic [CNT_W-1:0]      out_cnt_q;
  logic [CNT_W-1:0]      disc_cnt_q;
  logic [CNT_W-1:0]      occ_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;

  logic [INST_WIDTH-1:0] mem_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc    [FIFO_DEPTH];
  logic                  mem_err   [FIFO_DEPTH];

  logic             gnt_acc;
  logic             rv_drop;
  logic             push;
  logic             pop;
  logic             credit;
  logic             head_from_in;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] occ_nxt;
  logic [CNT_W-1:0] disc_nxt;
  logic [PTR_W-1:0] rd_nxt;

  assign instr_addr_o = fetch_addr_q;

  // Next-cycle bookkeeping; a branch flushes the FIFO and marks everything in flight stale.
  always_comb begin
    gnt_acc      = instr_req_o & instr_gnt_i;
    rv_drop      = instr_rvalid_i & (branch_i | (disc_cnt_q != '0));
    push         = instr_rvalid_i & ~rv_drop & (occ_q != CNT_W'(FIFO_DEPTH));
    pop          = valid_o & ready_i & ~branch_i;
    out_nxt      = out_cnt_q + CNT_W'(gnt_acc) - CNT_W'(instr_rvalid_i);
    occ_nxt      = occ_q + CNT_W'(push) - CNT_W'(pop);
    disc_nxt     = disc_cnt_q - CNT_W'(instr_rvalid_i && (disc_cnt_q != '0))
                   + CNT_W'(gnt_acc && (state_q == REDIR));
    rd_nxt       = rd_ptr_q + PTR_W'(pop);
    head_from_in = push && (occ_q == CNT_W'(pop));
    if (branch_i) begin
      occ_nxt  = '0;
      disc_nxt = out_nxt;
      rd_nxt   = wr_ptr_q;
    end
    credit = (SUM_W'(occ_nxt) + SUM_W'(out_nxt)) < SUM_W'(FIFO_DEPTH);
  end

  // FIFO storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= instr_rdata_i;
      mem_pc[wr_ptr_q]    <= resp_pc_q;
      mem_err[wr_ptr_q]   <= instr_err_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_req_o  <= 1'b0;
      fetch_addr_q <= BOOT_ADDR;
      redir_addr_q <= BOOT_ADDR;
      resp_pc_q    <= BOOT_ADDR;
      out_cnt_q    <= '0;
      disc_cnt_q   <= '0;
      occ_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      valid_o      <= 1'b0;
      instr_o      <= '0;
      pc_o         <= '0;
      err_o        <= 1'b0;
    end else begin
      out_cnt_q  <= out_nxt;
      disc_cnt_q <= disc_nxt;
      occ_q      <= occ_nxt;
      rd_ptr_q   <= rd_nxt;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push);
      valid_o    <= (occ_nxt != '0);

      if (branch_i) begin
        resp_pc_q <= branch_addr_i;
      end else if (push) begin
        resp_pc_q <= resp_pc_q + STEP;
      end

      // Head entry: straight from the bus when the FIFO drains to empty this cycle.
      if (head_from_in) begin
        instr_o <= instr_rdata_i;
        pc_o    <= resp_pc_q;
        err_o   <= instr_err_i;
      end else if (occ_nxt != '0) begin
        instr_o <= mem_instr[rd_nxt];
        pc_o    <= mem_pc[rd_nxt];
        err_o   <= mem_err[rd_nxt];
      end

      unique case (state_q)
        IDLE: begin
          if (branch_i) begin
            fetch_addr_q <= branch_addr_i;
          end
          if (credit) begin
            state_q     <= REQ;
            instr_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (gnt_acc) begin
            fetch_addr_q <= branch_i ? branch_addr_i : fetch_addr_q + STEP;
            state_q      <= credit ? REQ : IDLE;
            instr_req_o  <= credit;
          end else if (branch_i) begin
            redir_addr_q <= branch_addr_i;
            state_q      <= REDIR;
          end
        end
        REDIR: begin
          // The held request still goes out; the newest target follows it.
          if (branch_i) begin
            redir_addr_q <= branch_addr_i;
          end
          if (gnt_acc) begin
            fetch_addr_q <= branch_i ? branch_addr_i : redir_addr_q;
            state_q      <= credit ? REQ : IDLE;
            instr_req_o  <= credit;
          end
        end
        default: begin
          state_q     <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized bus/decode/branch traffic checked each
// cycle against a program-order stream model, plus a few pinned directed cases.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;

  instr_fetch_unit #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT)
  ) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .err_o(err_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Stimulus controls
  int gnt_pct, rv_pct, ready_pct, br_pm, lat_min, lat_max;
  bit rst_v = 1'b1;
  bit force_br = 1'b0;
  logic [31:0] force_tgt;
  bit hold_en = 1'b0;
  logic [31:0] hold_addr;
  bit live_en = 1'b0;

  // Model state
  logic [31:0] exp_pc = BOOT, exp_fetch = BOOT, redir_tgt = '0, prev_addr = '0;
  bit stale = 1'b0, flush_chk = 1'b0, prev_pend = 1'b0;
  bit rst_h1 = 1'b1, rst_h2 = 1'b1;
  logic [31:0] bq_addr[$];
  int bq_due[$];
  int idle_cnt = 0;

  // Logs for pinned expectations
  logic [31:0] glog[$];
  logic [31:0] dlog_pc[$];
  bit dlog_err[$];
  int first_gnt_cyc, first_val_cyc;
  logic [31:0] first_after_br;
  bit want_after_br = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return (a[5:2] == 4'd3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    glog.delete(); dlog_pc.delete(); dlog_err.delete();
    first_gnt_cyc = -1; first_val_cyc = -1; first_after_br = 32'hDEAD_BEEF;
  endtask

  // One clock: check outputs, drive inputs, advance the model across the coming edge.
  task automatic cycle();
    logic g, rv, br, rdy;
    logic [31:0] ba;
    @(negedge clk);
    cyc++;
    if (rst_h1) begin
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
    end else begin
      if (rst_h2) begin
        chk("boot_req", 32'(instr_req_o), 32'd1);
        chk("boot_addr", instr_addr_o, BOOT);
      end
      if (prev_pend) begin
        chk("hold_req", 32'(instr_req_o), 32'd1);
        chk("hold_addr", instr_addr_o, prev_addr);
      end
      if (flush_chk) chk("flush_valid", 32'(valid_o), 32'd0);
      if (valid_o) begin
        chk("head_pc", pc_o, exp_pc);
        chk("head_instr", instr_o, memf(exp_pc));
        chk("head_err", 32'(err_o), 32'(errf(exp_pc)));
        if (first_val_cyc < 0) first_val_cyc = cyc;
        if (want_after_br) begin first_after_br = pc_o; want_after_br = 1'b0; end
      end
      chk("outstanding_bound", 32'(bq_addr.size() <= DEPTH), 32'd1);
      if (live_en) chk("liveness", 32'(idle_cnt < 120), 32'd1);
    end

    g = 1'b0; rv = 1'b0; br = 1'b0; rdy = 1'b0; ba = '0;
    if (!rst_v) begin
      rdy = ($urandom_range(99) < ready_pct);
      g = ($urandom_range(99) < gnt_pct) && !(hold_en && instr_addr_o == hold_addr);
      if (force_br) begin
        br = 1'b1; ba = force_tgt; force_br = 1'b0; want_after_br = 1'b1;
      end else if ($urandom_range(999) < br_pm) begin
        br = 1'b1;
        ba = $urandom_range(1) ? ($urandom() & 32'hFFFF_FFFC) : (32'hFFFF_FFF0 + 32'($urandom_range(3) * 4));
      end
      if (bq_addr.size() > 0 && bq_due[0] <= cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
    end
    rst = rst_v; branch_i = br; branch_addr_i = ba; ready_i = rdy;
    instr_gnt_i = g; instr_rvalid_i = rv;
    if (rv) begin
      instr_rdata_i = memf(bq_addr[0]); instr_err_i = errf(bq_addr[0]);
    end else begin
      instr_rdata_i = $urandom(); instr_err_i = 1'($urandom_range(1));
    end

    rst_h2 = rst_h1; rst_h1 = rst_v;
    if (rst_v) begin
      bq_addr.delete(); bq_due.delete();
      exp_pc = BOOT; exp_fetch = BOOT; stale = 1'b0;
      flush_chk = 1'b0; prev_pend = 1'b0; idle_cnt = 0; want_after_br = 1'b0;
    end else begin
      if (rv) begin void'(bq_addr.pop_front()); void'(bq_due.pop_front()); end
      if (instr_req_o && g) begin
        chk("gnt_addr", instr_addr_o, exp_fetch);
        glog.push_back(instr_addr_o);
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        bq_addr.push_back(instr_addr_o);
        bq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        if (stale) begin exp_fetch = redir_tgt; stale = 1'b0; end
        else exp_fetch = instr_addr_o + 32'd4;
      end
      if (br) begin
        if (instr_req_o && !g) begin stale = 1'b1; redir_tgt = ba; end
        else exp_fetch = ba;
        exp_pc = ba; flush_chk = 1'b1; idle_cnt = 0;
      end else begin
        flush_chk = 1'b0;
        if (valid_o && rdy) begin
          dlog_pc.push_back(pc_o); dlog_err.push_back(err_o);
          exp_pc = exp_pc + 32'd4; idle_cnt = 0;
        end else idle_cnt++;
      end
      prev_pend = instr_req_o && !g;
      prev_addr = instr_addr_o;
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    repeat (2) cycle();
    rst_v = 1'b0;
    clear_logs();
  endtask

  task automatic setup(input int gp, input int rp, input int dp, input int bp,
                       input int lmin, input int lmax);
    gnt_pct = gp; rv_pct = rp; ready_pct = dp; br_pm = bp; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    int n;
    int base;
    setup(100, 100, 100, 0, 1, 1);
    clear_logs();

    // Streaming with single-cycle responses
    do_reset();
    repeat (30) cycle();
    chk("first_valid_latency", 32'(first_val_cyc - first_gnt_cyc), 32'd2);
    chk("gnt0", (glog.size() > 2) ? glog[0] : 32'hFFFF_FFFF, 32'h0);
    chk("gnt1", (glog.size() > 2) ? glog[1] : 32'hFFFF_FFFF, 32'h4);
    chk("gnt2", (glog.size() > 2) ? glog[2] : 32'hFFFF_FFFF, 32'h8);
    chk("pc0", (dlog_pc.size() > 3) ? dlog_pc[0] : 32'hFFFF_FFFF, 32'h0);
    chk("pc1", (dlog_pc.size() > 3) ? dlog_pc[1] : 32'hFFFF_FFFF, 32'h4);
    chk("pc2", (dlog_pc.size() > 3) ? dlog_pc[2] : 32'hFFFF_FFFF, 32'h8);
    chk("err_pc0", (dlog_err.size() > 3) ? 32'(dlog_err[0]) : 32'd9, 32'd0);
    chk("err_pcC", (dlog_err.size() > 3) ? 32'(dlog_err[3]) : 32'd9, 32'd1);

    // Decode stall fills the buffer and stops requests, then drains losslessly
    ready_pct = 0;
    repeat (20) cycle();
    chk("stall_req", 32'(instr_req_o), 32'd0);
    chk("stall_valid", 32'(valid_o), 32'd1);
    base = dlog_pc.size();
    ready_pct = 100;
    repeat (30) cycle();
    chk("resume_progress", 32'(dlog_pc.size() >= base + 5), 32'd1);

    // Branch with two responses in flight
    setup(100, 100, 100, 0, 4, 4);
    do_reset();
    n = 0;
    while (bq_addr.size() != 2 && n < 50) begin cycle(); n++; end
    chk("wait_two_outstanding", 32'(n < 50), 32'd1);
    force_tgt = 32'h100; force_br = 1'b1;
    repeat (25) cycle();
    chk("branch_first_pc", first_after_br, 32'h100);

    // Branch while a request is held ungranted
    setup(100, 100, 100, 0, 1, 1);
    do_reset();
    hold_en = 1'b1; hold_addr = 32'h8;
    n = 0;
    while (!(instr_req_o && instr_addr_o == 32'h8) && n < 50) begin cycle(); n++; end
    chk("wait_req_at_8", 32'(n < 50), 32'd1);
    force_tgt = 32'h40; force_br = 1'b1;
    repeat (4) cycle();
    hold_en = 1'b0;
    repeat (20) cycle();
    chk("held_gnt", (glog.size() > 3) ? glog[2] : 32'hFFFF_FFFF, 32'h8);
    chk("redir_gnt", (glog.size() > 3) ? glog[3] : 32'hFFFF_FFFF, 32'h40);
    chk("redir_first_pc", first_after_br, 32'h40);

    // Randomized traffic with branches and mid-stream resets
    live_en = 1'b1;
    for (int blk = 0; blk < 5; blk++) begin
      if (blk == 4) setup(60, 80, 15, 20, 1, 3);
      else setup(70, 70, 70, 30, 1, 4);
      do_reset();
      repeat (700) cycle();
    end
    live_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
